// File: rtl/dm_access_ctrl.sv
// Data-memory access sequencer: round-robin arbiter between two requesters, word/sub-word
// loads and read-modify-write sub-word stores. Define DM_TRACE_EN to print every memory write.
module dm_access_ctrl #(
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          a_req,
    input  logic          a_we,
    input  logic [1:0]    a_size,
    input  logic          a_signed,
    input  logic [31:0]   a_addr,
    input  logic [31:0]   a_wdata,
    input  logic [31:0]   a_pc,
    output logic          a_ack,
    output logic          a_err,
    output logic [31:0]   a_rdata,
    input  logic          b_req,
    input  logic          b_we,
    input  logic [1:0]    b_size,
    input  logic          b_signed,
    input  logic [31:0]   b_addr,
    input  logic [31:0]   b_wdata,
    input  logic [31:0]   b_pc,
    output logic          b_ack,
    output logic          b_err,
    output logic [31:0]   b_rdata,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata,
    output logic          busy
);

    typedef enum logic [1:0] {IDLE, ACCESS, MERGE, ACK} state_t;

    localparam logic       GRANT_A = 1'b0;
    localparam logic       GRANT_B = 1'b1;
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    state_t      state, next_state;
    logic        last_grant, grant_q;
    logic        we_q, signed_q, err_q;
    logic [1:0]  size_q;
    logic [31:0] addr_q, wdata_q, pc_q, merge_q;
    logic [31:0] a_rdata_q, b_rdata_q;
    logic        pick_b, misaligned, partial;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_data, merged;

    // On a tie the requester that was not served last wins.
    assign pick_b  = b_req && (!a_req || last_grant == GRANT_A);
    assign partial = we_q && (size_q == SZ_BYTE || size_q == SZ_HALF);

    always_comb begin
        misaligned = 1'b0;
        case (size_q)
            SZ_HALF: misaligned = addr_q[0];
            SZ_WORD: misaligned = |addr_q[1:0];
            SZ_RSVD: misaligned = 1'b1;
            default: misaligned = 1'b0;
        endcase
    end

    always_comb begin
        byte_sel  = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
        half_sel  = mem_rdata[{addr_q[1], 4'b0000} +: 16];
        load_data = mem_rdata;
        merged    = mem_rdata;
        case (size_q)
            SZ_BYTE: begin
                load_data = {{24{signed_q & byte_sel[7]}}, byte_sel};
                merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
            end
            SZ_HALF: begin
                load_data = {{16{signed_q & half_sel[15]}}, half_sel};
                merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
            end
            default: begin
                load_data = mem_rdata;
                merged    = mem_rdata;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (a_req || b_req) next_state = ACCESS;
            ACCESS:  next_state = (!misaligned && partial) ? MERGE : ACK;
            MERGE:   next_state = ACK;
            ACK:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_grant <= GRANT_B;
            grant_q    <= GRANT_A;
            we_q       <= 1'b0;
            signed_q   <= 1'b0;
            err_q      <= 1'b0;
            size_q     <= SZ_BYTE;
            addr_q     <= '0;
            wdata_q    <= '0;
            pc_q       <= '0;
            merge_q    <= '0;
            a_rdata_q  <= '0;
            b_rdata_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (a_req || b_req) begin
                        grant_q    <= pick_b;
                        last_grant <= pick_b;
                        we_q       <= pick_b ? b_we     : a_we;
                        size_q     <= pick_b ? b_size   : a_size;
                        signed_q   <= pick_b ? b_signed : a_signed;
                        addr_q     <= pick_b ? b_addr   : a_addr;
                        wdata_q    <= pick_b ? b_wdata  : a_wdata;
                        pc_q       <= pick_b ? b_pc     : a_pc;
                    end
                end
                ACCESS: begin
                    err_q <= misaligned;
                    if (!misaligned && !we_q) begin
                        if (grant_q == GRANT_B) b_rdata_q <= load_data;
                        else                    a_rdata_q <= load_data;
                    end
                    if (!misaligned && partial) merge_q <= merged;
                end
                default: ;
            endcase
        end
    end

    // Memory controls depend only on the state and the latched request.
    assign mem_addr  = addr_q[AW+1:2];
    assign mem_we    = (state == MERGE) ||
                       (state == ACCESS && we_q && size_q == SZ_WORD && !misaligned);
    assign mem_wdata = (state == MERGE) ? merge_q : wdata_q;

    assign a_ack   = (state == ACK) && (grant_q == GRANT_A);
    assign b_ack   = (state == ACK) && (grant_q == GRANT_B);
    assign a_err   = a_ack && err_q;
    assign b_err   = b_ack && err_q;
    assign a_rdata = a_rdata_q;
    assign b_rdata = b_rdata_q;
    assign busy    = (state != IDLE);

`ifdef DM_TRACE_EN
    always @(posedge clk) begin
        if (reset && mem_we)
            $display("@%08h: *%08h <= %08h", pc_q, {addr_q[31:2], 2'b00}, mem_wdata);
    end
`else
    logic unused_trace;
    assign unused_trace = ^{pc_q, addr_q[31:AW+2]};
`endif

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Scoreboard bench for dm_access_ctrl with a behavioural 1024-word memory
// (combinational read, clocked write).
module tb_dm_access_ctrl;
    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          reset;
    logic          a_req, a_we, a_signed, b_req, b_we, b_signed;
    logic [1:0]    a_size, b_size;
    logic [31:0]   a_addr, a_wdata, a_pc, b_addr, b_wdata, b_pc;
    logic          a_ack, a_err, b_ack, b_err;
    logic [31:0]   a_rdata, b_rdata;
    logic [AW-1:0] mem_addr;
    logic          mem_we, busy;
    logic [31:0]   mem_wdata, mem_rdata;
    logic [31:0]   mem [0:1023];

    dm_access_ctrl #(.AW(AW)) dut (
        .clk(clk), .reset(reset),
        .a_req(a_req), .a_we(a_we), .a_size(a_size), .a_signed(a_signed),
        .a_addr(a_addr), .a_wdata(a_wdata), .a_pc(a_pc),
        .a_ack(a_ack), .a_err(a_err), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_size(b_size), .b_signed(b_signed),
        .b_addr(b_addr), .b_wdata(b_wdata), .b_pc(b_pc),
        .b_ack(b_ack), .b_err(b_err), .b_rdata(b_rdata),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;

    typedef struct {
        string       tag;
        logic        err;
        logic        chk;
        logic [31:0] rdata;
        int          lat;
        int          seq;
    } exp_t;

    exp_t          qa[$];
    exp_t          qb[$];
    int            vectors = 0, miscompares = 0;
    int            cyc = 0, startA = 0, startB = 0;
    int            seqNext = 0, ackSeq = 0, weCount = 0;
    logic [AW-1:0] weIdx = '0;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input string tag, input bit portB, input logic we,
                                 input logic [1:0] size, input logic sgn,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic err, input logic chk,
                                 input logic [31:0] rdata, input int lat);
        exp_t e;
        e.tag = tag; e.err = err; e.chk = chk; e.rdata = rdata; e.lat = lat;
        e.seq = seqNext;
        seqNext++;
        if (!portB) begin
            a_we = we; a_size = size; a_signed = sgn; a_addr = addr; a_wdata = wdata;
            a_pc = 32'h0000_1000 + addr; a_req = 1'b1; startA = cyc;
            qa.push_back(e);
        end else begin
            b_we = we; b_size = size; b_signed = sgn; b_addr = addr; b_wdata = wdata;
            b_pc = 32'h0000_2000 + addr; b_req = 1'b1; startB = cyc;
            qb.push_back(e);
        end
    endtask

    task automatic handleAck(input bit portB);
        exp_t        e;
        logic        have, err_o;
        logic [31:0] rd_o;
        int          start;
        have = portB ? (qb.size() != 0) : (qa.size() != 0);
        checkOutput(portB ? "ack_b_expected" : "ack_a_expected", 32'(have), 32'd1);
        if (have) begin
            if (portB) begin
                e = qb.pop_front(); err_o = b_err; rd_o = b_rdata; start = startB; b_req = 1'b0;
            end else begin
                e = qa.pop_front(); err_o = a_err; rd_o = a_rdata; start = startA; a_req = 1'b0;
            end
            checkOutput({e.tag, "_order"}, ackSeq, e.seq);
            ackSeq++;
            checkOutput({e.tag, "_err"}, 32'(err_o), 32'(e.err));
            if (e.chk) checkOutput({e.tag, "_rdata"}, rd_o, e.rdata);
            if (e.lat >= 0) checkOutput({e.tag, "_latency"}, cyc - start, e.lat);
        end
    endtask

    // Steps negedge by negedge until every pushed expectation has been acked,
    // then spends one idle cycle confirming no extra ack shows up.
    task automatic waitAcks(input int budget);
        int n;
        n = 0;
        weCount = 0;
        while ((qa.size() != 0 || qb.size() != 0) && n < budget) begin
            @(negedge clk);
            n++; cyc++;
            if (mem_we) begin weCount++; weIdx = mem_addr; end
            if (a_ack) handleAck(1'b0);
            if (b_ack) handleAck(1'b1);
        end
        checkOutput("pending_after_wait", qa.size() + qb.size(), 32'd0);
        @(negedge clk);
        cyc++;
        if (mem_we) begin weCount++; weIdx = mem_addr; end
        checkOutput("no_extra_ack", 32'({a_ack, b_ack}), 32'd0);
    endtask

    initial begin
        reset = 1'b0;
        a_req = 0; a_we = 0; a_size = 0; a_signed = 0; a_addr = 0; a_wdata = 0; a_pc = 0;
        b_req = 0; b_we = 0; b_size = 0; b_signed = 0; b_addr = 0; b_wdata = 0; b_pc = 0;
        repeat (3) @(negedge clk);
        checkOutput("rst_a_ack", 32'(a_ack), 32'd0);
        checkOutput("rst_b_ack", 32'(b_ack), 32'd0);
        checkOutput("rst_a_err", 32'(a_err), 32'd0);
        checkOutput("rst_b_err", 32'(b_err), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_mem_we", 32'(mem_we), 32'd0);
        checkOutput("rst_a_rdata", a_rdata, 32'd0);
        checkOutput("rst_b_rdata", b_rdata, 32'd0);
        checkOutput("rst_mem_addr", 32'(mem_addr), 32'd0);
        checkOutput("rst_mem_wdata", mem_wdata, 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // Ties: A wins first after reset, then alternation; B waits behind A.
        applyStimulus("tie1_a", 1'b0, 1'b1, 2'b10, 1'b0, 32'h40, 32'h0A0A_0A0A, 1'b0, 1'b0, 32'h0, 2);
        applyStimulus("tie1_b", 1'b1, 1'b1, 2'b10, 1'b0, 32'h44, 32'h0B0B_0B0B, 1'b0, 1'b0, 32'h0, 5);
        waitAcks(20);
        applyStimulus("tie2_a", 1'b0, 1'b0, 2'b10, 1'b0, 32'h44, 32'h0, 1'b0, 1'b1, 32'h0B0B_0B0B, 2);
        applyStimulus("tie2_b", 1'b1, 1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 1'b0, 1'b1, 32'h0A0A_0A0A, 5);
        waitAcks(20);

        applyStimulus("st_word", 1'b0, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0, 2);
        waitAcks(10);
        checkOutput("st_word_we_count", weCount, 32'd1);
        checkOutput("st_word_we_idx", 32'(weIdx), 32'd4);
        checkOutput("st_word_mem", mem[4], 32'hDEAD_BEEF);
        applyStimulus("ld_word", 1'b0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0, 1'b1, 32'hDEAD_BEEF, 2);
        waitAcks(10);
        applyStimulus("ld_alias", 1'b1, 1'b0, 2'b10, 1'b0, 32'h1010, 32'h0, 1'b0, 1'b1, 32'hDEAD_BEEF, 2);
        waitAcks(10);

        applyStimulus("st_w20", 1'b0, 1'b1, 2'b10, 1'b0, 32'h20, 32'h1122_3344, 1'b0, 1'b0, 32'h0, 2);
        waitAcks(10);
        applyStimulus("st_byte22", 1'b1, 1'b1, 2'b00, 1'b0, 32'h22, 32'hFFFF_FFAB, 1'b0, 1'b0, 32'h0, 3);
        waitAcks(10);
        checkOutput("st_byte_we_count", weCount, 32'd1);
        checkOutput("st_byte_we_idx", 32'(weIdx), 32'd8);
        checkOutput("st_byte_mem", mem[8], 32'h11AB_3344);

        applyStimulus("st_w30", 1'b0, 1'b1, 2'b10, 1'b0, 32'h30, 32'h8000_80FF, 1'b0, 1'b0, 32'h0, 2);
        waitAcks(10);
        applyStimulus("ld_b30_s", 1'b0, 1'b0, 2'b00, 1'b1, 32'h30, 32'h0, 1'b0, 1'b1, 32'hFFFF_FFFF, 2);
        waitAcks(10);
        applyStimulus("ld_b30_u", 1'b1, 1'b0, 2'b00, 1'b0, 32'h30, 32'h0, 1'b0, 1'b1, 32'h0000_00FF, 2);
        waitAcks(10);
        applyStimulus("ld_h32_s", 1'b0, 1'b0, 2'b01, 1'b1, 32'h32, 32'h0, 1'b0, 1'b1, 32'hFFFF_8000, 2);
        waitAcks(10);
        applyStimulus("ld_h32_u", 1'b1, 1'b0, 2'b01, 1'b0, 32'h32, 32'h0, 1'b0, 1'b1, 32'h0000_8000, 2);
        waitAcks(10);
        applyStimulus("ld_b31_s", 1'b0, 1'b0, 2'b00, 1'b1, 32'h31, 32'h0, 1'b0, 1'b1, 32'hFFFF_FF80, 2);
        waitAcks(10);
        applyStimulus("st_h32", 1'b0, 1'b1, 2'b01, 1'b0, 32'h32, 32'hFFFF_1234, 1'b0, 1'b0, 32'h0, 3);
        waitAcks(10);
        applyStimulus("ld_w30", 1'b1, 1'b0, 2'b10, 1'b0, 32'h30, 32'h0, 1'b0, 1'b1, 32'h1234_80FF, 2);
        waitAcks(10);

        applyStimulus("err_st13", 1'b0, 1'b1, 2'b10, 1'b0, 32'h13, 32'h5555_5555, 1'b1, 1'b0, 32'h0, 2);
        waitAcks(10);
        checkOutput("err_st13_we_count", weCount, 32'd0);
        checkOutput("err_st13_mem", mem[4], 32'hDEAD_BEEF);
        applyStimulus("err_rsvd", 1'b1, 1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 32'h0, 2);
        waitAcks(10);
        applyStimulus("err_h31", 1'b0, 1'b0, 2'b01, 1'b0, 32'h31, 32'h0, 1'b1, 1'b0, 32'h0, 2);
        waitAcks(10);
        applyStimulus("err_bst12", 1'b1, 1'b1, 2'b10, 1'b0, 32'h12, 32'h0, 1'b1, 1'b0, 32'h0, 2);
        waitAcks(10);
        checkOutput("err_bst12_we_count", weCount, 32'd0);

        // Byte store cut by reset while in MERGE: no write, no ack.
        b_we = 1'b1; b_size = 2'b00; b_signed = 1'b0; b_addr = 32'h21; b_wdata = 32'hCD;
        b_pc = 32'h0000_2021; b_req = 1'b1;
        @(negedge clk);
        checkOutput("rst_mid_access_busy", 32'(busy), 32'd1);
        @(negedge clk);
        checkOutput("rst_mid_merge_we", 32'(mem_we), 32'd1);
        reset = 1'b0;
        b_req = 1'b0;
        #1;
        checkOutput("rst_mid_busy", 32'(busy), 32'd0);
        checkOutput("rst_mid_we", 32'(mem_we), 32'd0);
        repeat (3) begin
            @(negedge clk);
            checkOutput("rst_mid_no_ack", 32'({a_ack, b_ack}), 32'd0);
        end
        reset = 1'b1;
        @(negedge clk);
        checkOutput("rst_mid_mem", mem[8], 32'h11AB_3344);
        checkOutput("rst_mid_b_rdata", b_rdata, 32'd0);
        applyStimulus("ld_after_rst", 1'b0, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 1'b0, 1'b1, 32'h11AB_3344, 2);
        waitAcks(10);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dm_access_ctrl.md
# dm_access_ctrl

Access sequencer and arbiter for the 1024-word data memory. Two requesters share the memory: port A (core load/store stage) and port B (loader/debug). The block round-robins between them and runs each transaction against a word-wide memory with combinational read and clocked write. Sub-word stores become a two-cycle read-modify-write; sub-word loads are extracted and extended.

## Interface
Parameters:
- `AW`, 10: memory word-index width. The word index is `addr[AW+1:2]`; higher address bits are ignored, so addresses alias every 4 KB.

Ports (x ∈ {a, b}, one identical set per requester):
- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-low reset
- `x_req`  in  1  request; held stable with all `x_*` inputs until `x_ack`
- `x_we`  in  1  1 = store, 0 = load
- `x_size`  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as error)
- `x_signed`  in  1  loads only: sign-extend (1) or zero-extend (0)
- `x_addr`  in  32  byte address
- `x_wdata`  in  32  store data, right-aligned
- `x_pc`  in  32  instruction address, used for tracing only
- `x_ack`  out  1  one-cycle completion pulse
- `x_err`  out  1  valid with `x_ack`: misaligned or reserved size, no memory access made
- `x_rdata`  out  32  load result, valid with `x_ack` and held until the next ack to this port
- `mem_addr`  out  AW  word index to memory
- `mem_we`  out  1  memory write enable
- `mem_wdata`  out  32  memory write data
- `mem_rdata`  in  32  memory read data, combinational from `mem_addr`
- `busy`  out  1  high whenever the state is not IDLE

## Operation
- FSM states: IDLE, ACCESS, MERGE, ACK.
- IDLE: if any `req` is high, grant one requester, latch its inputs, go to ACCESS.
  - Arbitration: if only one requester is asserting, it wins. If both are asserting, the one not granted last wins.
  - `last_grant` resets to B, so A wins the first tie.
- Alignment check is done on the latched request. Error cases: half with `addr[0]`=1, word with `addr[1:0]`≠0, size 11.
  - Error: ACCESS makes no memory access and sets the error flag; the FSM goes to ACK.
- ACCESS drives `mem_addr` = latched word index. Then, by request type:
  - Word store: `mem_we`=1, `mem_wdata`=wdata; go to ACK.
  - Load: capture `mem_rdata` and extract by lane; go to ACK.
    - Byte lane k = `addr[1:0]` gives bits [8k+7:8k].
    - Half: `addr[1]`=0 gives [15:0], 1 gives [31:16].
    - Extend per `x_signed`.
  - Byte/half store: capture `mem_rdata` into the merge register; go to MERGE.
    - Byte: lane k is replaced by `wdata[7:0]`.
    - Half: the selected half is replaced by `wdata[15:0]`.
- MERGE: `mem_we`=1 with the merged word, same `mem_addr`; go to ACK.
- ACK: pulse the granted `x_ack`, with `x_err`/`x_rdata` valid; go to IDLE.
- `mem_we`, `mem_addr` and `mem_wdata` decode only from the state register and latched registers. There are no combinational paths from `x_*` inputs.
- `mem_we` is 0 in IDLE and ACK, and in ACCESS for loads, errors and partial stores.

## Timing
- Request sampled in IDLE at edge N. Latency to `x_ack`:
  - Word store, load or error: ack high in cycle N+2.
  - Byte/half store: ack high in cycle N+3.
- The memory write happens at the edge ending the ACCESS cycle (word store) or the MERGE cycle (partial store).
- After ACK the FSM returns to IDLE for one cycle. The minimum request-to-request interval is 3 cycles (word/load) or 4 cycles (partial store).
- The requester must drop `req` in its ack cycle. A `req` still high in the next IDLE is treated as a new transaction.
- The requester not granted waits; its `req` is re-evaluated in every IDLE. No ack is lost.
- Reset values:
  - State IDLE, `last_grant`=B.
  - `a_ack`, `b_ack`, `a_err`, `b_err`, `busy`, `mem_we` = 0.
  - `a_rdata`, `b_rdata`, `mem_addr`, `mem_wdata` = 0.
- Reset asserted mid-transaction: immediate return to IDLE, no ack is issued, and the transaction is lost. A write edge that already occurred stands; MERGE is never half-completed.

## Configuration
- `DM_TRACE_EN` defined: on every memory write edge the block prints `@<pc>: *<addr> <= <data>`.
  - `<pc>` is the granted `x_pc`, in 8 hex digits.
  - `<addr>` is the word-aligned byte address `{addr[31:2],2'b00}`.
  - `<data>` is the full 32-bit word written, merged data for partial stores.
- `DM_TRACE_EN` undefined: no print statements are compiled; RTL behaviour is otherwise identical.

## Test plan
- A word store: addr 0x0000_0010, data 0xDEAD_BEEF -> one `mem_we` cycle at index 4; `a_ack` at N+2; load of the same address returns 0xDEAD_BEEF.
- Word 0x1122_3344 at 0x20, then B byte store 0xAB at 0x22 -> ack at N+3; memory reads 0x11AB_3344; trace shows `*00000020 <= 11ab3344`.
- Word 0x8000_80FF at 0x30, then loads:
  - byte at 0x30, signed -> 0xFFFF_FFFF; unsigned -> 0x0000_00FF.
  - half at 0x32, signed -> 0xFFFF_8000.
- A and B both request in the same IDLE, twice in a row -> grants A, B, A, B alternate; each ack arrives exactly once.
- A word store to 0x13 -> `a_err`=1 with ack at N+2; `mem_we` never asserted; memory unchanged.
- `reset` low during MERGE of a byte store -> no ack; target word unchanged; `busy`=0 immediately.
